// File: rtl/defuse_controller_if.sv
// Game-side signal bundle between the defuse controller and its surroundings
// (button/switch inputs, face-driver restart, status and countdown outputs).
// Signalling contract: start/enter are raw asynchronous button levels; a
// press is one rising edge. code_in is a static switch level read on the
// ENTER event cycle. restart is a clk-synchronous level. All outputs are
// registered levels. No valid/ready handshake is involved.
interface defuse_controller_if;
  logic       start;
  logic       enter;
  logic [7:0] code_in;
  logic       restart;
  logic       armed;
  logic       success;
  logic       fail;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] tries_left;

  modport master (
    output start, enter, code_in, restart,
    input  armed, success, fail, sec_tens, sec_ones, tries_left
  );

  modport slave (
    input  start, enter, code_in, restart,
    output armed, success, fail, sec_tens, sec_ones, tries_left
  );
endinterface

// File: rtl/defuse_controller.sv
// defuse_controller: bomb-game core FSM. Arms a countdown, checks the switch
// code on each ENTER press and ends in DEFUSED or EXPLODED.
// Optional feature macro: STRIKE_PENALTY_EN (a wrong entry also removes
// PENALTY seconds, saturating at 00). Undefined by default.
// dbg_state exposes the FSM state for checkers.
module defuse_controller #(
  parameter logic [7:0] CODE      = 8'hA5,
  parameter int         TICK_DIV  = 50_000_000,
  parameter int         TIME_SEC  = 60,
  parameter int         MAX_TRIES = 3,
  parameter int         PENALTY   = 10
) (
  input  logic                clk,
  input  logic                rst,
  defuse_controller_if.slave  gif,
  output logic [1:0]          dbg_state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [6:0]    SEC_INIT   = 7'(TIME_SEC);
  localparam logic [1:0]    TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_DEFUSED  = 2'd2,
    S_EXPLODED = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [6:0]    secs, secs_n, step;
  logic [1:0]    tries, tries_n;
  logic [PW-1:0] presc, presc_n;
  logic          tick;
  logic [2:0]    start_sync, enter_sync;
  logic          start_ev, enter_ev, code_ok;

  // Binary seconds -> {tens, ones} BCD for the 7-segment driver.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Two-flop synchronizers plus a delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync <= '0;
      enter_sync <= '0;
    end else begin
      start_sync <= {start_sync[1:0], gif.start};
      enter_sync <= {enter_sync[1:0], gif.enter};
    end
  end

  assign start_ev  = start_sync[1] & ~start_sync[2];
  assign enter_ev  = enter_sync[1] & ~enter_sync[2];
  assign code_ok   = (gif.code_in == CODE);
  assign dbg_state = state;

  // Next-state and next-value computation for the game FSM.
  always_comb begin
    state_n = state;
    secs_n  = secs;
    tries_n = tries;
    presc_n = presc;
    tick    = 1'b0;
    step    = '0;
    case (state)
      S_IDLE: begin
        if (start_ev) begin
          state_n = S_ARMED;
          secs_n  = SEC_INIT;
          tries_n = TRIES_INIT;
          presc_n = '0;
        end
      end
      S_ARMED: begin
        tick = (presc == PRESC_LAST);
        if (enter_ev && code_ok) begin
          // A correct entry wins over any same-cycle tick; time freezes.
          state_n = S_DEFUSED;
        end else begin
          presc_n = tick ? '0 : presc + 1'b1;
          step    = {6'd0, tick};
`ifdef STRIKE_PENALTY_EN
          if (enter_ev) step = step + 7'(PENALTY);
`endif
          secs_n = (secs > step) ? secs - step : '0;
          if (enter_ev) tries_n = tries - 2'd1;
          if ((secs_n == 7'd0) || (enter_ev && tries == 2'd1))
            state_n = S_EXPLODED;
        end
      end
      S_DEFUSED, S_EXPLODED: begin
        if (gif.restart) begin
          state_n = S_IDLE;
          secs_n  = SEC_INIT;
          tries_n = TRIES_INIT;
          presc_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM state, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      secs           <= SEC_INIT;
      tries          <= TRIES_INIT;
      presc          <= '0;
      gif.armed      <= 1'b0;
      gif.success    <= 1'b0;
      gif.fail       <= 1'b0;
      {gif.sec_tens, gif.sec_ones} <= to_bcd(SEC_INIT);
      gif.tries_left <= TRIES_INIT;
    end else begin
      state          <= state_n;
      secs           <= secs_n;
      tries          <= tries_n;
      presc          <= presc_n;
      gif.armed      <= (state_n == S_ARMED);
      gif.success    <= (state_n == S_DEFUSED);
      gif.fail       <= (state_n == S_EXPLODED);
      {gif.sec_tens, gif.sec_ones} <= to_bcd(secs_n);
      gif.tries_left <= tries_n;
    end
  end

endmodule

// File: tb/tb_defuse_controller.sv
// Bench for defuse_controller with TICK_DIV=4, TIME_SEC=12, MAX_TRIES=3,
// CODE=8'hA5. Expected output snapshots {armed,success,fail,tens,ones,tries}
// are queued as stimulus is driven and popped when the outputs are sampled.
module tb_defuse_controller;
  localparam int W = 13;
`ifdef STRIKE_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  defuse_controller_if gif();

  defuse_controller #(
    .CODE(8'hA5), .TICK_DIV(4), .TIME_SEC(12), .MAX_TRIES(3), .PENALTY(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gif(gif.slave),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (a,s,f,tens,ones,tries)", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] snap(input logic a, input logic s, input logic f,
                                        input logic [3:0] t, input logic [3:0] o,
                                        input logic [1:0] tr);
    return {a, s, f, t, o, tr};
  endfunction

  function automatic logic [W-1:0] observed();
    return {gif.armed, gif.success, gif.fail, gif.sec_tens, gif.sec_ones, gif.tries_left};
  endfunction

  task automatic push_exp(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [W-1:0] e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, observed(), e);
    end
  endtask

  // Driver tasks; each returns 1 ns after the edge where the effect lands.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    @(negedge clk); gif.start = 1'b1;
    @(posedge clk);
    @(negedge clk); gif.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic press_enter(input logic [7:0] code);
    @(negedge clk); gif.enter = 1'b1; gif.code_in = code;
    @(posedge clk);
    @(negedge clk); gif.enter = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_restart();
    @(negedge clk); gif.restart = 1'b1;
    @(posedge clk); #1;
    gif.restart = 1'b0;
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gif.start = 1'b0; gif.enter = 1'b0; gif.code_in = 8'h00; gif.restart = 1'b0;
    clocks(2);
    push_exp("reset", snap(0, 0, 0, 4'd1, 4'd2, 2'd3)); pop_check();
    @(negedge clk); rst = 1'b0;

    // 1: arming latency and countdown
    push_exp("arm_pre", snap(0, 0, 0, 4'd1, 4'd2, 2'd3));
    @(negedge clk); gif.start = 1'b1;
    @(posedge clk);
    @(negedge clk); gif.start = 1'b0;
    @(posedge clk); #1;
    pop_check();
    push_exp("arm", snap(1, 0, 0, 4'd1, 4'd2, 2'd3));
    clocks(1); pop_check();
    push_exp("cnt3", snap(1, 0, 0, 4'd1, 4'd2, 2'd3));
    clocks(3); pop_check();
    push_exp("cnt4", snap(1, 0, 0, 4'd1, 4'd1, 2'd3));
    clocks(1); pop_check();
    push_exp("cnt12", snap(1, 0, 0, 4'd0, 4'd9, 2'd3));
    clocks(8); pop_check();

    // 2: correct code defuses and freezes, restart reloads
    push_exp("defuse", snap(0, 1, 0, 4'd0, 4'd9, 2'd3));
    press_enter(8'hA5); pop_check();
    push_exp("defuse_hold", snap(0, 1, 0, 4'd0, 4'd9, 2'd3));
    clocks(8); pop_check();
    push_exp("restart1", snap(0, 0, 0, 4'd1, 4'd2, 2'd3));
    do_restart(); pop_check();

    // 3: three wrong entries
    push_exp("arm3", snap(1, 0, 0, 4'd1, 4'd2, 2'd3));
    press_start(); pop_check();
    push_exp("wrong1", PEN ? snap(1, 0, 0, 4'd0, 4'd2, 2'd2)
                           : snap(1, 0, 0, 4'd1, 4'd2, 2'd2));
    press_enter(8'h00); pop_check();
    push_exp("wrong2", PEN ? snap(0, 0, 1, 4'd0, 4'd0, 2'd1)
                           : snap(1, 0, 0, 4'd1, 4'd1, 2'd1));
    press_enter(8'h00); pop_check();
    push_exp("wrong3", PEN ? snap(0, 0, 1, 4'd0, 4'd0, 2'd1)
                           : snap(0, 0, 1, 4'd1, 4'd0, 2'd0));
    press_enter(8'h00); pop_check();
    push_exp("explode_hold", PEN ? snap(0, 0, 1, 4'd0, 4'd0, 2'd1)
                                 : snap(0, 0, 1, 4'd1, 4'd0, 2'd0));
    clocks(8); pop_check();
    push_exp("restart3", snap(0, 0, 0, 4'd1, 4'd2, 2'd3));
    do_restart(); pop_check();

    // 4: timeout after 48 clocks
    press_start();
    push_exp("to47", snap(1, 0, 0, 4'd0, 4'd1, 2'd3));
    clocks(47); pop_check();
    push_exp("to48", snap(0, 0, 1, 4'd0, 4'd0, 2'd3));
    clocks(1); pop_check();
    push_exp("late_enter", snap(0, 0, 1, 4'd0, 4'd0, 2'd3));
    press_enter(8'hA5); pop_check();
    push_exp("late_start", snap(0, 0, 1, 4'd0, 4'd0, 2'd3));
    press_start(); pop_check();
    do_restart();

    // 5: correct entry on the final tick; then rst mid-game
    press_start();
    clocks(45);
    push_exp("race_defuse", snap(0, 1, 0, 4'd0, 4'd1, 2'd3));
    press_enter(8'hA5); pop_check();
    push_exp("race_hold", snap(0, 1, 0, 4'd0, 4'd1, 2'd3));
    clocks(4); pop_check();
    do_restart();
    press_start();
    push_exp("wrong5", PEN ? snap(1, 0, 0, 4'd0, 4'd2, 2'd2)
                           : snap(1, 0, 0, 4'd1, 4'd2, 2'd2));
    press_enter(8'h00); pop_check();
    push_exp("mid8", PEN ? snap(0, 0, 1, 4'd0, 4'd0, 2'd2)
                         : snap(1, 0, 0, 4'd1, 4'd0, 2'd2));
    clocks(5); pop_check();
    push_exp("rst_mid", snap(0, 0, 0, 4'd1, 4'd2, 2'd3));
    @(negedge clk); rst = 1'b1;
    clocks(1); pop_check();
    @(negedge clk); rst = 1'b0;

`ifdef STRIKE_PENALTY_EN
    // 6: penalty saturates and combines with a coincident tick
    press_start();
    clocks(2);
    push_exp("pen1", snap(1, 0, 0, 4'd0, 4'd1, 2'd2));
    press_enter(8'h00); pop_check();
    push_exp("pen2", snap(0, 0, 1, 4'd0, 4'd0, 2'd1));
    press_enter(8'h00); pop_check();
`endif

    check_val("sb_drain", W'(exp_q.size()), '0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
